iic_bus_cond: RTL and testbench
===============================

Name: iic_bus_cond

Overview:
Input conditioner and bus monitor between the I2C pads and the I2C master core on the DE0-Nano. It takes raw SCL/SDA pad levels, synchronises and glitch-filters them, and feeds the clean levels to the master's scl_in/sda_in. It also flags START, STOP, bus-busy and arbitration loss for the host and for the accelerometer polling logic.

Parameters:
FILT_CYCLES, 4, consecutive stable clocks required before a filtered line changes; legal range 1..255.
TIMEOUT_CYCLES, 50000, SCL-low clocks while busy before a bus timeout. Used only with IIC_TIMEOUT_EN.

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
scl_in  input  1  raw SCL pad level
sda_in  input  1  raw SDA pad level
sda_out  input  1  master SDA drive intent; 1 = released, 0 = pulling low
scl_f  output  1  filtered SCL to master
sda_f  output  1  filtered SDA to master
start_det  output  1  one-cycle pulse on START or repeated START
stop_det  output  1  one-cycle pulse on STOP
bus_busy  output  1  high between START and STOP
arb_lost  output  1  one-cycle pulse on arbitration loss
timeout  output  1  one-cycle pulse on SCL-low timeout; constant 0 without IIC_TIMEOUT_EN

Behaviour:
- Reset (async assert, sync release):
  - sync flops, scl_f and sda_f = 1 (idle bus).
  - Filter counters = 0.
  - start_det, stop_det, bus_busy, arb_lost, timeout = 0.
- Synchroniser: two flops per line. Raw input to synchronised level takes 2 clk.
- Filter, per line, with counter width ceil(log2(FILT_CYCLES+1)):
  - If synchronised level equals filtered output, counter clears to 0.
  - Otherwise counter increments. When it reaches FILT_CYCLES-1 and the mismatch persists, the output toggles and the counter clears.
  - Total latency from pad edge to filtered edge is 2 + FILT_CYCLES clk.
  - Pulses of FILT_CYCLES-1 clk or shorter never propagate.
  - The counter must not wrap; it saturates at the toggle point.
- Edge detect uses registered previous filtered values scl_p and sda_p, reset to 1.
- START: sda_p=1, sda_f=0, scl_p=1, scl_f=1. Effects:
  - start_det pulses for 1 clk.
  - bus_busy is set to 1; it stays 1 if already busy (repeated START still pulses).
- STOP: sda_p=0, sda_f=1, scl_p=1, scl_f=1. Effects:
  - stop_det pulses for 1 clk.
  - bus_busy clears.
- Simultaneous SCL and SDA change in the same clk: neither START nor STOP is reported.
- Outputs are registered: start_det, stop_det and the bus_busy update appear 1 clk after the filtered edge.
- Arbitration loss:
  - Condition: SCL rising edge (scl_p=0, scl_f=1) while bus_busy=1, sda_out=1 and sda_f=0.
  - Response: arb_lost pulses for 1 clk, registered.
  - No report when bus_busy=0.
- STOP with bus_busy=0 still pulses stop_det; bus_busy stays 0.
- No handshake; all pulses are single-cycle, and consumers sample them every clk.

Optional Feature:
Macro: IIC_TIMEOUT_EN.
- Defined:
  - A counter of width ceil(log2(TIMEOUT_CYCLES+1)) increments each clk while bus_busy=1 and scl_f=0.
  - It clears when scl_f=1, when bus_busy=0, or on start_det.
  - On reaching TIMEOUT_CYCLES: timeout pulses for 1 clk, bus_busy is forced to 0 the same edge, and the counter clears.
  - If a START edge occurs in the same clk as the timeout, START wins: bus_busy=1 and timeout is still pulsed.
- Not defined: no counter logic exists and timeout is tied 0.

Test Plan:
1. FILT_CYCLES=4, idle bus; 3-clk low glitch on sda_in -> sda_f stays 1, no start_det, bus_busy=0.
2. sda_in falls at t0 with scl_in=1 held -> sda_f falls at t0+6 clk, start_det high exactly at t0+7 for 1 clk, bus_busy=1 from t0+7.
3. Busy bus, second START (sda 1->0 with scl high) -> start_det pulses again, bus_busy stays 1. Then SDA 0->1 with scl high -> stop_det 1 clk, bus_busy=0.
4. Busy bus, sda_out=1, sda_in forced 0, scl_in rises -> arb_lost 1 clk, 7 clk after pad edge. Repeat with sda_out=0 -> no arb_lost.
5. Reset asserted mid-transfer (bus_busy=1, scl_f=0) -> all outputs immediately at reset values (scl_f=sda_f=1, others 0). After release with pads high, no spurious start_det or stop_det.
6. With IIC_TIMEOUT_EN and TIMEOUT_CYCLES=100: START, then hold scl_in low 120 clk -> timeout pulses once at the 100th SCL-low clk, bus_busy drops the same clk. Without the macro, the same stimulus gives timeout=0 and bus_busy=1.

Source files
------------

// File: rtl/iic_bus_cond.sv
// iic_bus_cond: I2C pad conditioner and bus monitor.
// Synchronises and glitch-filters raw SCL/SDA, then detects START, STOP,
// bus-busy and arbitration loss on the filtered levels.
// Optional feature macro: IIC_TIMEOUT_EN (SCL-low bus timeout).
module iic_bus_cond #(
  parameter int unsigned FILT_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  input  logic sda_out,
  output logic scl_f,
  output logic sda_f,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic arb_lost,
  output logic timeout
);

  localparam int unsigned   CW        = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(FILT_CYCLES - 1);

  // Elaboration-time guard on parameter ranges
  if (FILT_CYCLES < 1 || FILT_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("iic_bus_cond: parameter out of range");
  end

  // Bit 0 carries SCL, bit 1 carries SDA throughout
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [1:0]    prev;
  logic [CW-1:0] cnt [2];

  logic start_cond;
  logic stop_cond;
  logic arb_cond;
  logic to_hit;

  assign scl_f = filt[0];
  assign sda_f = filt[1];

  // Two-flop synchroniser per line, idle-high out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {sda_in, scl_in};
      sync2 <= sync1;
    end
  end

  // Per-line stability filter: toggle only after FILT_CYCLES consecutive mismatches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '1;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == FILT_LAST) begin
          filt[i] <= ~filt[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Previous filtered levels for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '1;
    else        prev <= filt;
  end

  // A simultaneous SCL change drops out naturally: both conditions need SCL high before and after
  assign start_cond = prev[1] & ~filt[1] & prev[0] & filt[0];
  assign stop_cond  = ~prev[1] & filt[1] & prev[0] & filt[0];
  assign arb_cond   = ~prev[0] & filt[0] & bus_busy & sda_out & ~filt[1];

`ifdef IIC_TIMEOUT_EN
  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;

  // Fires on the SCL-low clock that would bring the count to TIMEOUT_CYCLES
  assign to_hit = bus_busy & ~filt[0] & (to_cnt == TO_LAST);

  // SCL-low counter while the bus is held busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (!bus_busy || filt[0] || start_det || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // Registered event pulses and bus-busy tracking; START outranks timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      arb_lost  <= 1'b0;
      timeout   <= 1'b0;
      bus_busy  <= 1'b0;
    end else begin
      start_det <= start_cond;
      stop_det  <= stop_cond;
      arb_lost  <= arb_cond;
      timeout   <= to_hit;
      if (start_cond)               bus_busy <= 1'b1;
      else if (stop_cond || to_hit) bus_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iic_bus_cond.sv
// tb_iic_bus_cond: directed self-checking bench for iic_bus_cond
// (FILT_CYCLES=4, TIMEOUT_CYCLES=100).
module tb_iic_bus_cond;

  logic clk = 1'b0;
  logic rst_n;
  logic scl_in;
  logic sda_in;
  logic sda_out;
  logic scl_f;
  logic sda_f;
  logic start_det;
  logic stop_det;
  logic bus_busy;
  logic arb_lost;
  logic timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  iic_bus_cond #(
    .FILT_CYCLES   (4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_out  (sda_out),
    .scl_f    (scl_f),
    .sda_f    (sda_f),
    .start_det(start_det),
    .stop_det (stop_det),
    .bus_busy (bus_busy),
    .arb_lost (arb_lost),
    .timeout  (timeout)
  );

  // Advance n clocks, leaving time 1 unit past the rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    tick(2);
    tests++;
    if ({scl_f, sda_f, start_det, stop_det, bus_busy, arb_lost, timeout} !== 7'b1100000) begin
      fails++;
      $display("FAIL reset_outputs got %b exp %b",
               {scl_f, sda_f, start_det, stop_det, bus_busy, arb_lost, timeout}, 7'b1100000);
    end
    rst_n = 1'b1;
    tick(4);
    tests++;
    if ({scl_f, sda_f, start_det, stop_det, bus_busy} !== 5'b11000) begin
      fails++;
      $display("FAIL post_reset_idle got %b exp %b",
               {scl_f, sda_f, start_det, stop_det, bus_busy}, 5'b11000);
    end
  endtask

  task automatic test_glitch();
    logic seen_low = 1'b0;
    logic seen_start = 1'b0;
    logic seen_busy = 1'b0;
    sda_in = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      if (k == 3) sda_in = 1'b1;
      seen_low   |= ~sda_f;
      seen_start |= start_det;
      seen_busy  |= bus_busy;
    end
    tests++;
    if (seen_low !== 1'b0) begin
      fails++;
      $display("FAIL glitch_sda_f got low=%b exp low=0", seen_low);
    end
    tests++;
    if (seen_start !== 1'b0) begin
      fails++;
      $display("FAIL glitch_start got %b exp 0", seen_start);
    end
    tests++;
    if (seen_busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_busy got %b exp 0", seen_busy);
    end
  endtask

  task automatic test_start();
    logic [2:0] exp_v;
    sda_in = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      exp_v = {(k >= 6) ? 1'b0 : 1'b1, (k == 7) ? 1'b1 : 1'b0, (k >= 7) ? 1'b1 : 1'b0};
      tests++;
      if ({sda_f, start_det, bus_busy} !== exp_v) begin
        fails++;
        $display("FAIL start_t%0d {sda_f,start_det,busy} got %b exp %b",
                 k, {sda_f, start_det, bus_busy}, exp_v);
      end
    end
  endtask

  task automatic test_repeated_start_stop();
    int n_start = 0;
    int n_stop = 0;
    logic [1:0] exp_v;
    scl_in = 1'b0;
    for (int k = 0; k < 8; k++) begin tick(1); n_stop += int'(stop_det); n_start += int'(start_det); end
    sda_in = 1'b1;
    for (int k = 0; k < 8; k++) begin tick(1); n_stop += int'(stop_det); n_start += int'(start_det); end
    scl_in = 1'b1;
    for (int k = 0; k < 8; k++) begin tick(1); n_stop += int'(stop_det); n_start += int'(start_det); end
    sda_in = 1'b0;
    for (int k = 0; k < 10; k++) begin tick(1); n_stop += int'(stop_det); n_start += int'(start_det); end
    tests++;
    if (n_start != 1) begin
      fails++;
      $display("FAIL rstart_count got %0d exp 1", n_start);
    end
    tests++;
    if (n_stop != 0) begin
      fails++;
      $display("FAIL rstart_no_stop got %0d exp 0", n_stop);
    end
    tests++;
    if (bus_busy !== 1'b1) begin
      fails++;
      $display("FAIL rstart_busy got %b exp 1", bus_busy);
    end
    sda_in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      exp_v = {(k == 7) ? 1'b1 : 1'b0, (k < 7) ? 1'b1 : 1'b0};
      tests++;
      if ({stop_det, bus_busy} !== exp_v) begin
        fails++;
        $display("FAIL stop_t%0d {stop_det,busy} got %b exp %b", k, {stop_det, bus_busy}, exp_v);
      end
    end
  endtask

  task automatic test_arbitration();
    int n_arb = 0;
    sda_in = 1'b0;
    tick(10);
    scl_in = 1'b0;
    tick(8);
    sda_out = 1'b1;
    scl_in  = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      tests++;
      if (arb_lost !== ((k == 7) ? 1'b1 : 1'b0)) begin
        fails++;
        $display("FAIL arb_t%0d got %b exp %b", k, arb_lost, (k == 7) ? 1'b1 : 1'b0);
      end
    end
    scl_in = 1'b0;
    tick(8);
    sda_out = 1'b0;
    scl_in  = 1'b1;
    for (int k = 0; k < 10; k++) begin tick(1); n_arb += int'(arb_lost); end
    tests++;
    if (n_arb != 0) begin
      fails++;
      $display("FAIL arb_own_low got %0d pulses exp 0", n_arb);
    end
    sda_out = 1'b1;
    sda_in  = 1'b1;
    tick(10);
    tests++;
    if (bus_busy !== 1'b0) begin
      fails++;
      $display("FAIL arb_end_busy got %b exp 0", bus_busy);
    end
  endtask

  task automatic test_stop_idle();
    int n_arb = 0;
    logic [1:0] exp_v;
    scl_in = 1'b0;
    tick(8);
    sda_in = 1'b0;
    tick(8);
    scl_in = 1'b1;
    for (int k = 0; k < 10; k++) begin tick(1); n_arb += int'(arb_lost); end
    tests++;
    if (n_arb != 0) begin
      fails++;
      $display("FAIL arb_idle got %0d pulses exp 0", n_arb);
    end
    sda_in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      exp_v = {(k == 7) ? 1'b1 : 1'b0, 1'b0};
      tests++;
      if ({stop_det, bus_busy} !== exp_v) begin
        fails++;
        $display("FAIL stop_idle_t%0d {stop_det,busy} got %b exp %b", k, {stop_det, bus_busy}, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_ev = 0;
    sda_in = 1'b0;
    tick(10);
    scl_in = 1'b0;
    tick(10);
    tests++;
    if ({bus_busy, scl_f} !== 2'b10) begin
      fails++;
      $display("FAIL midrst_pre {busy,scl_f} got %b exp %b", {bus_busy, scl_f}, 2'b10);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({scl_f, sda_f, start_det, stop_det, bus_busy, arb_lost, timeout} !== 7'b1100000) begin
      fails++;
      $display("FAIL midrst_async got %b exp %b",
               {scl_f, sda_f, start_det, stop_det, bus_busy, arb_lost, timeout}, 7'b1100000);
    end
    scl_in = 1'b1;
    sda_in = 1'b1;
    tick(3);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin tick(1); n_ev += int'(start_det) + int'(stop_det); end
    tests++;
    if (n_ev != 0 || bus_busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_release got events=%0d busy=%b exp events=0 busy=0", n_ev, bus_busy);
    end
  endtask

  task automatic test_timeout();
    int   n_to = 0;
    int   first_k = -1;
    logic busy_at_hit = 1'bx;
    logic busy_before = 1'bx;
    sda_in = 1'b0;
    tick(10);
    scl_in = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      tick(1);
      if (k == 105) busy_before = bus_busy;
      if (timeout === 1'b1) begin
        n_to++;
        if (first_k < 0) begin
          first_k     = k;
          busy_at_hit = bus_busy;
        end
      end
    end
`ifdef IIC_TIMEOUT_EN
    tests++;
    if (n_to != 1) begin
      fails++;
      $display("FAIL timeout_count got %0d exp 1", n_to);
    end
    tests++;
    if (first_k != 106) begin
      fails++;
      $display("FAIL timeout_cycle got %0d exp 106", first_k);
    end
    tests++;
    if ({busy_before, busy_at_hit} !== 2'b10) begin
      fails++;
      $display("FAIL timeout_busy {before,at} got %b exp %b", {busy_before, busy_at_hit}, 2'b10);
    end
`else
    tests++;
    if (n_to != 0) begin
      fails++;
      $display("FAIL timeout_disabled got %0d pulses exp 0 (first at %0d)", n_to, first_k);
    end
    tests++;
    if ({busy_before, bus_busy} !== 2'b11) begin
      fails++;
      $display("FAIL timeout_disabled_busy got %b exp %b", {busy_before, bus_busy}, 2'b11);
    end
`endif
  endtask

  initial begin
    rst_n   = 1'b0;
    scl_in  = 1'b1;
    sda_in  = 1'b1;
    sda_out = 1'b1;
    test_reset();
    test_glitch();
    test_start();
    test_repeated_start_stop();
    test_arbitration();
    test_stop_idle();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
